gerador_fruta: RTL

- Fruit-position generator that sits directly upstream of the snake update FSM.
- Keeps one pre-validated empty map cell on fruta_wx/fruta_wy, flagged by fruta_valid.
- The update FSM consumes it by pulsing fruta_wenable when it writes the fruit. The generator then searches for a new empty cell.
- Uses its own read port on the map memory, with LFSR-random attempts first and a linear-scan fallback after that.

---
 rtl/gerador_fruta.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gerador_fruta.sv
// gerador_fruta: keeps one pre-validated empty map cell ready for the snake
// update FSM. Searches with LFSR-random candidates first and falls back to a
// linear scan once MAX_TENTATIVAS random reads have all hit occupied cells.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   fruta_wenable     consume pulse (only honoured while fruta_valid=1)
//   fruta_wx/wy       validated empty cell (column/row)
//   fruta_valid       fruta_wx/wy hold a validated empty cell
//   gen_renable       map read request (registered)
//   gen_rx/gen_ry     map read column/row (registered)
//   gen_rdata         map cell contents, 4'b0000 = empty, valid one cycle
//                     after the read request was sampled
//   mapa_cheio        no empty cell exists; sticky until reset
module gerador_fruta #(
  parameter int          MAPA_HEIGHT    = 30,
  parameter int          MAPA_WIDTH     = 40,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          MAX_TENTATIVAS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fruta_wenable,
  output logic [9:0] fruta_wx,
  output logic [9:0] fruta_wy,
  output logic       fruta_valid,
  output logic       gen_renable,
  output logic [9:0] gen_rx,
  output logic [9:0] gen_ry,
  input  logic [3:0] gen_rdata,
  output logic       mapa_cheio
);

  localparam int CELLS = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int TW    = $clog2(MAX_TENTATIVAS + 1);
  localparam int SW    = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    SORTEIA, LE, CHECA, VARRE_SORTEIA, VARRE_LE, VARRE_CHECA, IDLE, CHEIO
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   lfsr;
  logic [TW-1:0] tentativas;
  logic [SW-1:0] varre_cnt;
  logic [9:0]    cx, cy, nx_x, nx_y;
  logic          vazio, esgotou, varre_fim;

  // Scale the 8-bit random bytes into [0, dim) without a divider.
  assign cx = 10'((32'(lfsr[7:0])  * 32'(MAPA_WIDTH))  >> 8);
  assign cy = 10'((32'(lfsr[15:8]) * 32'(MAPA_HEIGHT)) >> 8);

  // Next raster position after (gen_rx, gen_ry), wrapping at the map edge.
  always_comb begin
    nx_x = gen_rx + 10'd1;
    nx_y = gen_ry;
    if (gen_rx == 10'(MAPA_WIDTH - 1)) begin
      nx_x = 10'd0;
      nx_y = (gen_ry == 10'(MAPA_HEIGHT - 1)) ? 10'd0 : gen_ry + 10'd1;
    end
  end

  assign vazio     = (gen_rdata == 4'b0000);
  assign esgotou   = (tentativas >= TW'(MAX_TENTATIVAS));
  assign varre_fim = (varre_cnt == SW'(CELLS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      SORTEIA:       state_nx = LE;
      LE:            state_nx = CHECA;
      CHECA:         state_nx = vazio ? IDLE : (esgotou ? VARRE_SORTEIA : SORTEIA);
      VARRE_SORTEIA: state_nx = VARRE_LE;
      VARRE_LE:      state_nx = VARRE_CHECA;
      VARRE_CHECA:   state_nx = vazio ? IDLE : (varre_fim ? CHEIO : VARRE_SORTEIA);
      IDLE:          state_nx = fruta_wenable ? SORTEIA : IDLE;
      CHEIO:         state_nx = CHEIO;
      default:       state_nx = SORTEIA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SORTEIA;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= SEED;
      tentativas  <= '0;
      varre_cnt   <= '0;
      fruta_wx    <= '0;
      fruta_wy    <= '0;
      fruta_valid <= 1'b0;
      gen_renable <= 1'b0;
      gen_rx      <= '0;
      gen_ry      <= '0;
      mapa_cheio  <= 1'b0;
    end else begin
      // Free-running so that the player's timing perturbs the sequence.
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        SORTEIA: begin
          gen_rx      <= cx;
          gen_ry      <= cy;
          gen_renable <= 1'b1;
          tentativas  <= tentativas + 1'b1;
        end
        LE, VARRE_LE: gen_renable <= 1'b0;
        CHECA: begin
          if (vazio) begin
            fruta_wx    <= gen_rx;
            fruta_wy    <= gen_ry;
            fruta_valid <= 1'b1;
            tentativas  <= '0;
          end else if (esgotou) begin
            // Scan resumes from the last candidate, which gen_rx/ry still hold.
            varre_cnt <= '0;
          end
        end
        VARRE_SORTEIA: begin
          gen_rx      <= nx_x;
          gen_ry      <= nx_y;
          gen_renable <= 1'b1;
        end
        VARRE_CHECA: begin
          if (vazio) begin
            fruta_wx    <= gen_rx;
            fruta_wy    <= gen_ry;
            fruta_valid <= 1'b1;
            tentativas  <= '0;
          end else begin
            varre_cnt <= varre_cnt + 1'b1;
            if (varre_fim) mapa_cheio <= 1'b1;
          end
        end
        IDLE: if (fruta_wenable) fruta_valid <= 1'b0;
        CHEIO: begin
          fruta_valid <= 1'b0;
          gen_renable <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
